// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the write unit and the read-side mux users.
package regfile_pkg;
   localparam int NUM_REGS       = 16;
   localparam int ADDR_W         = 4;
   localparam int PC_IDX_DEFAULT = 15;
   localparam int DATA_W         = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;
endpackage

// File: rtl/regfile_write_unit_write_decoder.sv
// 4-to-16 one-hot decoder; all-zero output when disabled.
module write_decoder
   import regfile_pkg::*;
(
   input  logic                en,
   input  logic [ADDR_W-1:0]   addr,
   output logic [NUM_REGS-1:0] onehot
);
   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end
endmodule

// File: rtl/regfile_write_unit.sv
// Register-bank write side: valid/ready write queue committing one entry per cycle,
// plus a dedicated PC load path that loses to a same-cycle queued commit.
module regfile_write_unit
   import regfile_pkg::*;
#(
   parameter int N      = DATA_W,
   parameter int DEPTH  = 2,
   parameter int PC_IDX = PC_IDX_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [ADDR_W-1:0]     wr_addr_i,
   input  logic [N-1:0]          wr_data_i,
   input  logic                  pc_en_i,
   input  logic [N-1:0]          pc_next_i,
   output logic [NUM_REGS*N-1:0] regs_o,
   output logic [NUM_REGS-1:0]   pending_o,
   output logic                  commit_o,
   output logic [ADDR_W-1:0]     commit_addr_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [N-1:0]      data;
   } entry_t;

   entry_t               q_mem [DEPTH];
   logic [PTR_W-1:0]     head;
   logic [PTR_W-1:0]     tail;
   logic [CNT_W-1:0]     count;
   logic [N-1:0]         bank [NUM_REGS];
   logic                 push;
   logic                 commit_en;
   logic [NUM_REGS-1:0]  wr_en;
   logic [DEPTH-1:0]     pend_en;
   logic [NUM_REGS-1:0]  pend_oh [DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign wr_ready_o = rst_n_i && (count < CNT_W'(DEPTH));
   assign push       = wr_valid_i && wr_ready_o;
   assign commit_en  = (count != '0);

   write_decoder u_bank_dec (
      .en     (commit_en),
      .addr   (q_mem[head].addr),
      .onehot (wr_en)
   );

   // An entry is occupied when its distance from head is below the fill count.
   always_comb begin
      logic [PTR_W-1:0] offset;
      offset  = '0;
      pend_en = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset     = PTR_W'(i) - head;
         pend_en[i] = CNT_W'(offset) < count;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_pend
      write_decoder u_pend_dec (
         .en     (pend_en[g]),
         .addr   (q_mem[g].addr),
         .onehot (pend_oh[g])
      );
   end

   always_comb begin
      pending_o = '0;
      for (int i = 0; i < DEPTH; i++) pending_o = pending_o | pend_oh[i];
   end

   always_ff @(posedge clk_i) begin
      if (push) q_mem[tail] <= '{addr: wr_addr_i, data: wr_data_i};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         commit_o      <= 1'b0;
         commit_addr_o <= '0;
         for (int k = 0; k < NUM_REGS; k++) bank[k] <= '0;
      end else begin
         if (push)      tail <= ptr_inc(tail);
         if (commit_en) head <= ptr_inc(head);
         if (push && !commit_en)      count <= count + 1'b1;
         else if (!push && commit_en) count <= count - 1'b1;
         commit_o <= commit_en;
         if (commit_en) commit_addr_o <= q_mem[head].addr;
         for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_en[k])                      bank[k] <= q_mem[head].data;
            else if (k == PC_IDX && pc_en_i)   bank[k] <= pc_next_i;
         end
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
      assign regs_o[k*N +: N] = bank[k];
   end
endmodule

// File: tb/tb_regfile_write_unit.sv
// Bench for regfile_write_unit: directed vector table, reset sequences and random traffic
// checked against a queue-based reference model.
module tb_regfile_write_unit;
   localparam int N     = 32;
   localparam int DEPTH = 2;
   localparam int PC    = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_valid;
   logic          wr_ready;
   logic [3:0]    wr_addr;
   logic [N-1:0]  wr_data;
   logic          pc_en;
   logic [N-1:0]  pc_next;
   logic [16*N-1:0] regs;
   logic [15:0]   pending;
   logic          commit;
   logic [3:0]    commit_addr;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0]   addr;
      logic [N-1:0] data;
   } ent_t;

   ent_t         mq[$];
   logic [N-1:0] mregs [16];

   typedef struct {
      bit           v;
      logic [3:0]   a;
      logic [N-1:0] d;
      bit           pe;
      logic [N-1:0] pv;
      bit           e_commit;
      logic [3:0]   e_caddr;
      logic [15:0]  e_pend;
      bit           rchk;
      logic [3:0]   ridx;
      logic [N-1:0] rval;
   } vec_t;

   vec_t vecs[13];

   regfile_write_unit #(.N(N), .DEPTH(DEPTH), .PC_IDX(PC)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .wr_valid_i    (wr_valid),
      .wr_ready_o    (wr_ready),
      .wr_addr_i     (wr_addr),
      .wr_data_i     (wr_data),
      .pc_en_i       (pc_en),
      .pc_next_i     (pc_next),
      .regs_o        (regs),
      .pending_o     (pending),
      .commit_o      (commit),
      .commit_addr_o (commit_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [511:0] model_regs();
      logic [511:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) r[k*N +: N] = mregs[k];
      return r;
   endfunction

   function automatic logic [15:0] model_pending();
      logic [15:0] p;
      p = '0;
      foreach (mq[i]) p[mq[i].addr] = 1'b1;
      return p;
   endfunction

   // One clock of normal operation, checked against the model.
   task automatic step(input bit v, input logic [3:0] a, input logic [N-1:0] d,
                       input bit pe, input logic [N-1:0] pv);
      bit         rdy;
      bit         cm;
      logic [3:0] ca;
      ent_t       e;
      @(negedge clk);
      wr_valid = v; wr_addr = a; wr_data = d; pc_en = pe; pc_next = pv;
      #1;
      rdy = (mq.size() < DEPTH);
      chk("ready", {511'b0, wr_ready}, {511'b0, rdy});
      @(posedge clk);
      if (pe) mregs[PC] = pv;
      cm = (mq.size() > 0);
      ca = '0;
      if (cm) begin
         e = mq.pop_front();
         mregs[e.addr] = e.data;
         ca = e.addr;
      end
      if (v && rdy) mq.push_back('{addr: a, data: d});
      #1;
      chk("commit", {511'b0, commit}, {511'b0, cm});
      if (cm) chk("commit_addr", {508'b0, commit_addr}, {508'b0, ca});
      chk("pending", {496'b0, pending}, {496'b0, model_pending()});
      chk("regs", regs, model_regs());
   endtask

   task automatic do_reset(input int cycles, input logic [3:0] a);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         rst_n = 1'b0; wr_valid = 1'b1; wr_addr = a; wr_data = $urandom;
         pc_en = 1'b1; pc_next = $urandom;
         #1;
         chk("ready_in_reset", {511'b0, wr_ready}, 512'd0);
         @(posedge clk);
         #1;
         chk("reset_regs", regs, 512'd0);
         chk("reset_pending", {496'b0, pending}, 512'd0);
         chk("reset_commit", {511'b0, commit}, 512'd0);
      end
      mq.delete();
      for (int k = 0; k < 16; k++) mregs[k] = '0;
      @(negedge clk);
      rst_n = 1'b1; wr_valid = 1'b0; pc_en = 1'b0;
      #1;
      chk("ready_after_reset", {511'b0, wr_ready}, 512'd1);
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; pc_en = 1'b0; pc_next = '0;
      for (int k = 0; k < 16; k++) mregs[k] = '0;

      //            v     a      d             pe    pv          ec    eca    epend      rc    ri     rv
      vecs[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 32'h0,      1'b0, 4'd0,  16'h0008, 1'b0, 4'd0,  32'h0};
      vecs[1]  = '{1'b0, 4'd0,  32'h0,        1'b0, 32'h0,      1'b1, 4'd3,  16'h0000, 1'b1, 4'd3,  32'hDEADBEEF};
      vecs[2]  = '{1'b1, 4'd1,  32'd11,       1'b0, 32'h0,      1'b0, 4'd0,  16'h0002, 1'b0, 4'd0,  32'h0};
      vecs[3]  = '{1'b1, 4'd2,  32'd12,       1'b0, 32'h0,      1'b1, 4'd1,  16'h0004, 1'b1, 4'd1,  32'd11};
      vecs[4]  = '{1'b1, 4'd3,  32'd13,       1'b0, 32'h0,      1'b1, 4'd2,  16'h0008, 1'b1, 4'd2,  32'd12};
      vecs[5]  = '{1'b1, 4'd4,  32'd14,       1'b0, 32'h0,      1'b1, 4'd3,  16'h0010, 1'b1, 4'd3,  32'd13};
      vecs[6]  = '{1'b0, 4'd0,  32'h0,        1'b0, 32'h0,      1'b1, 4'd4,  16'h0000, 1'b1, 4'd4,  32'd14};
      vecs[7]  = '{1'b1, 4'd5,  32'hAAAA,     1'b0, 32'h0,      1'b0, 4'd0,  16'h0020, 1'b0, 4'd0,  32'h0};
      vecs[8]  = '{1'b1, 4'd5,  32'hBBBB,     1'b0, 32'h0,      1'b1, 4'd5,  16'h0020, 1'b1, 4'd5,  32'hAAAA};
      vecs[9]  = '{1'b0, 4'd0,  32'h0,        1'b0, 32'h0,      1'b1, 4'd5,  16'h0000, 1'b1, 4'd5,  32'hBBBB};
      vecs[10] = '{1'b1, 4'd15, 32'h200,      1'b0, 32'h0,      1'b0, 4'd0,  16'h8000, 1'b0, 4'd0,  32'h0};
      vecs[11] = '{1'b0, 4'd0,  32'h0,        1'b1, 32'h100,    1'b1, 4'd15, 16'h0000, 1'b1, 4'd15, 32'h200};
      vecs[12] = '{1'b0, 4'd0,  32'h0,        1'b1, 32'h104,    1'b0, 4'd0,  16'h0000, 1'b1, 4'd15, 32'h104};

      do_reset(2, 4'd0);

      foreach (vecs[i]) begin
         step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].pe, vecs[i].pv);
         chk($sformatf("vec%0d_commit", i), {511'b0, commit}, {511'b0, vecs[i].e_commit});
         if (vecs[i].e_commit)
            chk($sformatf("vec%0d_caddr", i), {508'b0, commit_addr}, {508'b0, vecs[i].e_caddr});
         chk($sformatf("vec%0d_pending", i), {496'b0, pending}, {496'b0, vecs[i].e_pend});
         if (vecs[i].rchk)
            chk($sformatf("vec%0d_reg", i), {480'b0, regs[vecs[i].ridx*N +: N]}, {480'b0, vecs[i].rval});
      end

      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 32'($urandom),
              $urandom_range(0, 3) == 0, 32'($urandom));

      do_reset(2, 4'($urandom_range(0, 15)));

      // Reset while addr 7 is queued and addr 8 is being presented.
      step(1'b1, 4'd7, 32'h7777, 1'b0, 32'h0);
      do_reset(1, 4'd8);
      step(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      chk("mid_reset_reg7", {480'b0, regs[7*N +: N]}, 512'd0);
      chk("mid_reset_reg8", {480'b0, regs[8*N +: N]}, 512'd0);
      chk("mid_reset_no_commit", {511'b0, commit}, 512'd0);

      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)), 32'($urandom),
              $urandom_range(0, 1) == 0, 32'($urandom));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
